// File: rtl/pc_gen.sv
// Program-counter generator: boot sequencing, prioritised redirects with a
// one-entry pending latch for stalls, and a circular return-address stack.
module pc_gen #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_VEC = 32'h8000_0000,
  parameter bit               C_EXT     = 1'b0,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  input  logic            step_2,
  input  logic            exc_redirect,
  input  logic [XLEN-1:0] exc_target,
  input  logic            br_redirect,
  input  logic [XLEN-1:0] br_target,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ras_pop,
  output logic            pending
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {BOOT, RUN} state_t;

  state_t            state;
  logic              pend_is_exc;
  logic [XLEN-1:0]   pend_target;
  logic [XLEN-1:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0]     ras_ptr;
  logic [CW-1:0]     ras_cnt;

  logic              advance;
  logic              no_redir;
  logic              do_push;
  logic              do_pop;
  logic              ras_clear;
  logic              ras_we;
  logic [PW-1:0]     ras_waddr;
  logic [XLEN-1:0]   seq_pc;
  logic [XLEN-1:0]   next_pc;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    advance   = (state == RUN) && fetch_ready;
    no_redir  = advance && !exc_redirect && !pending && !br_redirect;
    do_pop    = no_redir && ras_pop && (ras_cnt != '0);
    do_push   = no_redir && ras_push;
    // A consumed pending exception counts as an exception redirect.
    ras_clear = advance && (exc_redirect || (pending && pend_is_exc));
    seq_pc    = fetch_pc + ((C_EXT && step_2) ? XLEN'(2) : XLEN'(4));
    ras_we    = do_push;
    ras_waddr = do_pop ? ras_ptr : ras_ptr + PW'(1);

    next_pc = seq_pc;
    if (exc_redirect)      next_pc = exc_target;
    else if (pending)      next_pc = pend_target;
    else if (br_redirect)  next_pc = br_target;
    else if (do_pop)       next_pc = ras_mem[ras_ptr];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      fetch_valid <= 1'b0;
      fetch_pc    <= RESET_VEC;
      pending     <= 1'b0;
      pend_is_exc <= 1'b0;
      pend_target <= '0;
      ras_ptr     <= '0;
      ras_cnt     <= '0;
    end else begin
      if (state == BOOT) begin
        state       <= RUN;
        fetch_valid <= 1'b1;
      end

      if (advance) begin
        fetch_pc <= next_pc;
        pending  <= 1'b0;
      end else if (exc_redirect) begin
        pending     <= 1'b1;
        pend_is_exc <= 1'b1;
        pend_target <= exc_target;
      end else if (br_redirect && !(pending && pend_is_exc)) begin
        pending     <= 1'b1;
        pend_is_exc <= 1'b0;
        pend_target <= br_target;
      end

      if (ras_clear) begin
        ras_cnt <= '0;
      end else if (do_push && do_pop) begin
        // Replace-top: pointer and count are unchanged.
      end else if (do_pop) begin
        ras_ptr <= ras_ptr - PW'(1);
        ras_cnt <= ras_cnt - CW'(1);
      end else if (do_push) begin
        ras_ptr <= ras_ptr + PW'(1);
        if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + CW'(1);
      end
    end
  end

  // NOTE: the stack storage is deliberately not reset; entries are only
  // readable when ras_cnt is non-zero.
  always_ff @(posedge clk) begin
    if (ras_we) ras_mem[ras_waddr] <= ras_push_addr;
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: two instances (C_EXT=0 and C_EXT=1) share stimulus.
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, fetch_ready, step_2, exc_redirect, br_redirect, ras_push, ras_pop;
  logic [31:0] exc_target, br_target, ras_push_addr;
  logic        fetch_valid, pending, fetch_valid_c, pending_c;
  logic [31:0] fetch_pc, fetch_pc_c;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_VEC(RV), .C_EXT(1'b0), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc), .step_2(step_2), .exc_redirect(exc_redirect),
    .exc_target(exc_target), .br_redirect(br_redirect), .br_target(br_target),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .pending(pending));

  pc_gen #(.XLEN(32), .RESET_VEC(RV), .C_EXT(1'b1), .RAS_DEPTH(4)) dut_c (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid_c),
    .fetch_pc(fetch_pc_c), .step_2(step_2), .exc_redirect(exc_redirect),
    .exc_target(exc_target), .br_redirect(br_redirect), .br_target(br_target),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .pending(pending_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_ready = 1'b1; step_2 = 1'b0; exc_redirect = 1'b0; br_redirect = 1'b0;
    ras_push = 1'b0; ras_pop = 1'b0;
    exc_target = '0; br_target = '0; ras_push_addr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); br_redirect = 1'b1; br_target = 32'h1234_5678;
    tick();
    rst = 1'b0; br_redirect = 1'b0;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL boot_valid got %b exp 0", fetch_valid); end
    checks++; if (fetch_pc !== RV) begin errors++; $display("FAIL boot_pc got %h exp %h", fetch_pc, RV); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL boot_pending got %b exp 0", pending); end
    tick();
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL run_valid got %b exp 1", fetch_valid); end
    checks++; if (fetch_pc !== RV) begin errors++; $display("FAIL run_pc0 got %h exp %h", fetch_pc, RV); end
    tick();
    checks++; if (fetch_pc !== 32'h8000_0004) begin errors++; $display("FAIL run_pc1 got %h exp 80000004", fetch_pc); end
    tick();
    checks++; if (fetch_pc !== 32'h8000_0008) begin errors++; $display("FAIL run_pc2 got %h exp 80000008", fetch_pc); end
  endtask

  task automatic test_pending();
    fetch_ready = 1'b0; br_redirect = 1'b1; br_target = 32'h8000_0100;
    tick();
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL pend_br got %b exp 1", pending); end
    checks++; if (fetch_pc !== 32'h8000_0008) begin errors++; $display("FAIL stall_hold got %h exp 80000008", fetch_pc); end
    br_redirect = 1'b0; exc_redirect = 1'b1; exc_target = 32'h8000_0200;
    tick();
    exc_redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (pending !== 1'b1) begin errors++; $display("FAIL pend_stall%0d got %b exp 1", i, pending); end
      if (i < 2) tick();
    end
    fetch_ready = 1'b1;
    tick();
    checks++; if (fetch_pc !== 32'h8000_0200) begin errors++; $display("FAIL pend_exc_pc got %h exp 80000200", fetch_pc); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL pend_clear got %b exp 0", pending); end
  endtask

  task automatic test_exc_priority();
    fetch_ready = 1'b0; exc_redirect = 1'b1; exc_target = 32'h8000_0200;
    tick();
    exc_redirect = 1'b0; br_redirect = 1'b1; br_target = 32'h8000_0300;
    tick();
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL exc_keep_pend got %b exp 1", pending); end
    fetch_ready = 1'b1; br_target = 32'h8000_0400;
    tick();
    br_redirect = 1'b0;
    checks++; if (fetch_pc !== 32'h8000_0200) begin errors++; $display("FAIL exc_not_overwritten got %h exp 80000200", fetch_pc); end
    tick();
    checks++; if (fetch_pc !== 32'h8000_0204) begin errors++; $display("FAIL live_br_discarded got %h exp 80000204", fetch_pc); end
    fetch_ready = 1'b0; br_redirect = 1'b1; br_target = 32'h8000_0500;
    tick();
    fetch_ready = 1'b1; br_redirect = 1'b0; exc_redirect = 1'b1; exc_target = 32'h8000_0600;
    tick();
    exc_redirect = 1'b0;
    checks++; if (fetch_pc !== 32'h8000_0600) begin errors++; $display("FAIL live_exc_wins got %h exp 80000600", fetch_pc); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL live_exc_clear got %b exp 0", pending); end
    tick();
    checks++; if (fetch_pc !== 32'h8000_0604) begin errors++; $display("FAIL after_exc_seq got %h exp 80000604", fetch_pc); end
  endtask

  task automatic test_ras();
    logic [31:0] addr [5];
    logic [31:0] exp_pc;
    for (int i = 0; i < 5; i++) addr[i] = 32'h8000_1000 + 32'(i) * 32'h100;
    ras_push = 1'b1;
    for (int i = 0; i < 5; i++) begin ras_push_addr = addr[i]; tick(); end
    ras_push = 1'b0; ras_pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (fetch_pc !== addr[4-i]) begin errors++; $display("FAIL ras_pop%0d got %h exp %h", i, fetch_pc, addr[4-i]); end
    end
    tick();
    exp_pc = addr[1] + 32'd4;
    checks++; if (fetch_pc !== exp_pc) begin errors++; $display("FAIL ras_pop_empty got %h exp %h", fetch_pc, exp_pc); end
    // replace-top: push X, push Y, push Z with pop -> Y, then Z, X, sequential
    ras_pop = 1'b0; ras_push = 1'b1; ras_push_addr = 32'h8000_2100; tick();
    ras_push_addr = 32'h8000_2200; tick();
    ras_pop = 1'b1; ras_push_addr = 32'h8000_2300; tick();
    ras_push = 1'b0;
    checks++; if (fetch_pc !== 32'h8000_2200) begin errors++; $display("FAIL ras_replace_pc got %h exp 80002200", fetch_pc); end
    tick();
    checks++; if (fetch_pc !== 32'h8000_2300) begin errors++; $display("FAIL ras_replaced_top got %h exp 80002300", fetch_pc); end
    tick();
    checks++; if (fetch_pc !== 32'h8000_2100) begin errors++; $display("FAIL ras_after_replace got %h exp 80002100", fetch_pc); end
    tick();
    checks++; if (fetch_pc !== 32'h8000_2104) begin errors++; $display("FAIL ras_replace_empty got %h exp 80002104", fetch_pc); end
    // branch with pop does not touch the stack
    ras_pop = 1'b0; ras_push = 1'b1; ras_push_addr = 32'h8000_2400; tick();
    ras_push = 1'b0; ras_pop = 1'b1; br_redirect = 1'b1; br_target = 32'h8000_3000; tick();
    br_redirect = 1'b0;
    checks++; if (fetch_pc !== 32'h8000_3000) begin errors++; $display("FAIL br_over_pop got %h exp 80003000", fetch_pc); end
    tick();
    checks++; if (fetch_pc !== 32'h8000_2400) begin errors++; $display("FAIL br_keeps_ras got %h exp 80002400", fetch_pc); end
    // exception empties the stack
    ras_pop = 1'b0; ras_push = 1'b1; ras_push_addr = 32'h8000_2500; tick();
    ras_push = 1'b0; exc_redirect = 1'b1; exc_target = 32'h8000_4000; tick();
    exc_redirect = 1'b0; ras_pop = 1'b1; tick();
    ras_pop = 1'b0;
    checks++; if (fetch_pc !== 32'h8000_4004) begin errors++; $display("FAIL exc_clears_ras got %h exp 80004004", fetch_pc); end
  endtask

  task automatic test_wrap();
    br_redirect = 1'b1; br_target = 32'hFFFF_FFFC; tick();
    br_redirect = 1'b0;
    checks++; if (fetch_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_br got %h exp fffffffc", fetch_pc); end
    tick();
    checks++; if (fetch_pc !== 32'h0000_0000) begin errors++; $display("FAIL wrap_seq got %h exp 00000000", fetch_pc); end
  endtask

  task automatic test_compressed();
    br_redirect = 1'b1; br_target = 32'h8000_0010; tick();
    br_redirect = 1'b0; step_2 = 1'b1; tick();
    checks++; if (fetch_pc_c !== 32'h8000_0012) begin errors++; $display("FAIL c_step2 got %h exp 80000012", fetch_pc_c); end
    checks++; if (fetch_pc !== 32'h8000_0014) begin errors++; $display("FAIL noc_step2 got %h exp 80000014", fetch_pc); end
    br_redirect = 1'b1; step_2 = 1'b0; tick();
    br_redirect = 1'b0; tick();
    checks++; if (fetch_pc_c !== 32'h8000_0014) begin errors++; $display("FAIL c_step4 got %h exp 80000014", fetch_pc_c); end
  endtask

  task automatic test_boot_latch();
    rst = 1'b1; idle_inputs(); tick();
    rst = 1'b0; br_redirect = 1'b1; br_target = 32'h8000_0700; tick();
    br_redirect = 1'b0;
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL boot_latch_pend got %b exp 1", pending); end
    checks++; if (fetch_pc !== RV) begin errors++; $display("FAIL boot_latch_hold got %h exp %h", fetch_pc, RV); end
    tick();
    checks++; if (fetch_pc !== 32'h8000_0700) begin errors++; $display("FAIL boot_latch_pc got %h exp 80000700", fetch_pc); end
  endtask

  task automatic test_reset_mid();
    ras_push = 1'b1;
    for (int i = 0; i < 3; i++) begin ras_push_addr = 32'h8000_5000 + 32'(i) * 32'h10; tick(); end
    ras_push = 1'b0; fetch_ready = 1'b0; br_redirect = 1'b1; br_target = 32'h8000_0900; tick();
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL mid_pend got %b exp 1", pending); end
    rst = 1'b1; fetch_ready = 1'b1; exc_redirect = 1'b1; exc_target = 32'h8000_0A00; tick();
    rst = 1'b0; br_redirect = 1'b0; exc_redirect = 1'b0;
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL mid_rst_pend got %b exp 0", pending); end
    checks++; if (fetch_pc !== RV) begin errors++; $display("FAIL mid_rst_pc got %h exp %h", fetch_pc, RV); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", fetch_valid); end
    tick();
    ras_pop = 1'b1; tick();
    ras_pop = 1'b0;
    checks++; if (fetch_pc !== RV + 32'd4) begin errors++; $display("FAIL mid_rst_pop got %h exp %h", fetch_pc, RV + 32'd4); end
  endtask

  initial begin
    rst = 1'b1; idle_inputs();
    tick();
    test_reset();
    test_pending();
    test_exc_priority();
    test_ras();
    test_wrap();
    test_compressed();
    test_boot_latch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC/target width.
REQ-002 SHALL have parameter RESET_VEC, default 32'h8000_0000, PC value loaded on reset.
REQ-003 SHALL have parameter C_EXT, default 0; 1 enables 2-byte sequential step.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, >=2).
REQ-005 SHALL have ports:
- clk  in  1  sole clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_ready  in  1  fetch stage accepts fetch_pc this cycle.
- fetch_valid  out  1  fetch_pc is valid.
- fetch_pc  out  XLEN  current PC.
- step_2  in  1  instruction at fetch_pc is compressed (used only if C_EXT=1).
- exc_redirect  in  1  exception redirect request.
- exc_target  in  XLEN  exception handler entry.
- br_redirect  in  1  branch/jump redirect request.
- br_target  in  XLEN  branch/jump target.
- ras_push  in  1  call detected at fetch_pc; push ras_push_addr.
- ras_push_addr  in  XLEN  return address to push.
- ras_pop  in  1  return predicted at fetch_pc; use RAS top.
- pending  out  1  a redirect is latched awaiting fetch_ready.

Function
REQ-006 SHALL implement states BOOT and RUN; reset enters BOOT; BOOT -> RUN unconditionally next cycle.
REQ-007 In BOOT, fetch_valid SHALL be 0 and fetch_pc SHALL hold RESET_VEC; in RUN, fetch_valid SHALL be 1.
REQ-008 SHALL update fetch_pc only in RUN on cycles with fetch_ready=1 (an "advance"); otherwise fetch_pc holds.
REQ-009 On advance, next PC priority SHALL be: live exc_redirect -> exc_target; else pending -> latched target; else live br_redirect -> br_target; else ras_pop with RAS non-empty -> RAS top; else sequential.
REQ-010 Sequential step SHALL be +2 when C_EXT=1 and step_2=1, else +4; addition modulo 2^XLEN (0xFFFF_FFFC +4 -> 0x0000_0000).
REQ-011 When fetch_ready=0 (or in BOOT), a redirect request SHALL be latched into the pending register instead of being dropped; pending=1 from the following cycle.
REQ-012 Latch rules: exception overwrites any pending entry; branch fills an empty entry or overwrites a pending branch; branch SHALL NOT overwrite a pending exception; exc and br in same cycle latch the exception.
REQ-013 On advance consuming the pending entry, pending SHALL clear in the same edge; a live br_redirect on that cycle SHALL be discarded; a live exc_redirect on that cycle wins and pending clears.
REQ-014 RAS SHALL be circular with pointer and saturating count 0..RAS_DEPTH; push on full overwrites oldest entry, count stays RAS_DEPTH.
REQ-015 ras_push/ras_pop SHALL take effect only on advance with no redirect selected; pop on empty SHALL be ignored (sequential PC used); push and pop together SHALL replace the top entry, count unchanged.
REQ-016 Any exception redirect taken on advance SHALL empty the RAS (count=0); branch redirect SHALL NOT alter the RAS.
REQ-017 All outputs SHALL be registered; no combinational path from inputs to fetch_pc or fetch_valid.

Reset
REQ-018 rst=1 at any edge SHALL force state BOOT, fetch_pc=RESET_VEC, fetch_valid=0, pending=0, RAS count=0, pointer=0, overriding all simultaneous inputs, including mid-redirect or mid-stall.
REQ-019 RAS entry contents need not be cleared; they SHALL be unobservable while count=0.

Verification
REQ-020 Reset release, fetch_ready=1 -> cycle 1 fetch_valid=0, pc=0x80000000; then 0x80000000, 0x80000004, 0x80000008.
REQ-021 fetch_ready=0, br_redirect to 0x80000100 for one cycle, then exc_redirect to 0x80000200, ready=1 after 3 cycles -> pending=1 throughout, next pc=0x80000200, pending=0.
REQ-022 Pending exception 0x80000200, then br to 0x80000300 while stalled -> next pc on advance = 0x80000200.
REQ-023 RAS_DEPTH=4: push A,B,C,D,E then pop x5 -> pops return E,D,C,B then sequential PC (A overwritten).
REQ-024 C_EXT=1, pc=0x80000010, step_2=1 -> 0x80000012; step_2=0 -> 0x80000014; C_EXT=0 with step_2=1 -> +4.
REQ-025 rst asserted while pending=1 and RAS count=3 -> next cycle pending=0, pc=0x80000000, subsequent pop yields sequential PC.
